sequential_divider: RTL and testbench
=====================================

# sequential_divider

Restoring shift-subtract divider: 10-bit unsigned dividend by 5-bit unsigned divisor, one quotient bit per clock, producing a 10-bit quotient and 5-bit remainder. It is the inverse companion of the 5x5 sequential multiplier in the MAC datapath: a 10-bit product from the multiplier divided by either original 5-bit operand returns the other operand with remainder 0. Single rising-edge design; no clock gating, no negedge registers.

## Interface
- Parameters: none. Widths are fixed at 10-bit dividend and 5-bit divisor to pair with the multiplier.
- div_clk_i  in  1  clock; all state updates on rising edge
- div_nreset_i  in  1  reset, asynchronous, active-low
- dividend_i  in  10  unsigned dividend, sampled only on the accepting edge
- divisor_i  in  5  unsigned divisor, sampled only on the accepting edge
- start_i  in  1  request; accepted on a rising edge when fetching_input_o=1
- quotient_o  out  10  result quotient register
- remainder_o  out  5  result remainder register
- is_result_o  out  1  one-cycle pulse: quotient_o and remainder_o were just updated
- fetching_input_o  out  1  block will accept start_i on the next edge (IDLE or DONE)
- busy_o  out  1  division in progress (RUN)
- div_by_zero_o  out  1  registered flag for the last accepted operation's divisor==0

## Operation
- States: IDLE, RUN, DONE. There is also a 4-bit iteration counter (0..9).
- Working registers:
  - R: 6-bit partial remainder.
  - Q: 10-bit dividend/quotient shift register.
  - D: 5-bit latched divisor.
- IDLE or DONE with start_i=1 and divisor_i!=0:
  - Q <= dividend_i, D <= divisor_i, R <= 0, count <= 0.
  - Next state RUN. div_by_zero_o <= 0.
- IDLE or DONE with start_i=1 and divisor_i==0:
  - Next state DONE directly.
  - quotient_o <= 10'h3FF, remainder_o <= 5'h00, div_by_zero_o <= 1.
- RUN, each edge:
  - Form {R',Q'} = {R[4:0],Q,1'b0}, i.e. shift left by one.
  - T = R'[5:0] - {1'b0,D}.
  - If T is non-negative (no borrow): R <= T[5:0] and Q <= {Q'[10:1],1'b1}.
  - Otherwise: R <= R' and Q <= {Q'[10:1],1'b0}.
  - count <= count+1.
- RUN with count==9, i.e. the 10th iteration edge:
  - quotient_o and remainder_o take the final Q and R[4:0] values of that iteration.
  - Next state DONE.
- R never exceeds D-1 ≤ 30 after restore, so R'≤61 fits in 6 bits and the final remainder fits in 5 bits.
- DONE lasts exactly one cycle, then the block returns to IDLE unless a new start is accepted. DONE behaves like IDLE for start acceptance.
- start_i in RUN is ignored; it is not queued.
- Result registers hold their value through IDLE and through any later RUN until the next result write.
- Reset (asynchronous, any state): state IDLE, count 0, R/Q/D 0.
  - quotient_o=0, remainder_o=0, div_by_zero_o=0, is_result_o=0, busy_o=0, fetching_input_o=1.
  - Reset mid-RUN abandons the operation and produces no result pulse.

## Timing
- Edge E0 accepts start. E1..E10 are the iterations. State is DONE after E10, so is_result_o is high between E10 and E11. Latency is 10 cycles from the accepting edge.
- Divide by zero: state is DONE after E0, so is_result_o is high between E0 and E1. Latency is 1 cycle.
- Throughput: a start held high at E10's DONE cycle is accepted at E11, giving back-to-back operations every 11 cycles.
- Output decodes, all from registered state:
  - is_result_o = (state==DONE)
  - busy_o = (state==RUN)
  - fetching_input_o = (state!=RUN)
- Operands may change freely after E0.

## Test plan
- 1000/7: dividend 10'h3E8, divisor 7, start at E0 → is_result_o pulse after E10 only; quotient 142 (10'h08E), remainder 6, div_by_zero_o 0, busy_o high exactly E0..E10.
- Multiplier inverse and extremes:
  - 961/31 → quotient 31, remainder 0.
  - 1023/1 → quotient 1023, remainder 0.
  - 5/31 → quotient 0, remainder 5.
  - 0/9 → quotient 0, remainder 0.
- Divide by zero: 10'h155/0 → pulse one cycle after E0; quotient 10'h3FF, remainder 0, div_by_zero_o 1. A following 20/3 → quotient 6, remainder 2, div_by_zero_o cleared.
- start_i toggled and operands changed during RUN of 1000/7 → ignored, result still 142 r 6. Previous result stays visible on quotient_o until E10.
- Reset: assert div_nreset_i asynchronously mid-RUN (after E5), away from clock edge → all outputs 0 immediately, fetching_input_o 1, no is_result_o pulse. A fresh 100/10 after release → quotient 10, remainder 0.
- Back-to-back: start held high continuously with 1000/7 then 961/31 (operands switched at DONE cycle) → pulses 11 cycles apart, results 142 r 6 then 31 r 0.

Source files
------------

// File: rtl/sequential_divider.sv
`default_nettype none
// ============================================================================
// sequential_divider: restoring 10-bit / 5-bit unsigned divider, 1 bit/clock
// Revision: 1.0
// ============================================================================
module sequential_divider (
    input  logic       div_clk_i,
    input  logic       div_nreset_i,
    input  logic [9:0] dividend_i,
    input  logic [4:0] divisor_i,
    input  logic       start_i,
    output logic [9:0] quotient_o,
    output logic [4:0] remainder_o,
    output logic       is_result_o,
    output logic       fetching_input_o,
    output logic       busy_o,
    output logic       div_by_zero_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;
    localparam logic [3:0] c_LAST = 4'd9;

    logic [1:0] state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [5:0] rem_q, rem_d;
    logic [9:0] quo_q, quo_d;
    logic [4:0] div_q, div_d;
    logic [9:0] quotient_q, quotient_d;
    logic [4:0] remainder_q, remainder_d;
    logic       dbz_q, dbz_d;

    logic       accept;
    logic [5:0] rem_shift;
    logic [6:0] diff;
    logic       borrow;
    logic [9:0] quo_next;
    logic [5:0] rem_next;

    always_ff @(posedge div_clk_i or negedge div_nreset_i) begin
        if (!div_nreset_i) begin
            state_q     <= c_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign accept = start_i && (state_q != c_RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE, c_DONE: begin
                if (start_i) begin
                    state_d = (divisor_i == 5'd0) ? c_DONE : c_RUN;
                end else begin
                    state_d = c_IDLE;
                end
            end
            c_RUN: begin
                if (count_q == c_LAST) begin
                    state_d = c_DONE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // One restoring step: shift the next dividend bit into R, trial-subtract D.
    assign rem_shift = {rem_q[4:0], quo_q[9]};
    assign diff      = {1'b0, rem_shift} - {2'b00, div_q};
    assign borrow    = diff[6];
    assign rem_next  = borrow ? rem_shift : diff[5:0];
    assign quo_next  = {quo_q[8:0], ~borrow};

    always_comb begin
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        if (accept) begin
            if (divisor_i == 5'd0) begin
                quotient_d  = 10'h3FF;
                remainder_d = 5'h00;
                dbz_d       = 1'b1;
            end else begin
                quo_d   = dividend_i;
                div_d   = divisor_i;
                rem_d   = '0;
                count_d = '0;
                dbz_d   = 1'b0;
            end
        end else if (state_q == c_RUN) begin
            rem_d   = rem_next;
            quo_d   = quo_next;
            count_d = count_q + 4'd1;
            if (count_q == c_LAST) begin
                quotient_d  = quo_next;
                remainder_d = rem_next[4:0];
            end
        end
    end

    always_comb begin
        is_result_o      = (state_q == c_DONE);
        busy_o           = (state_q == c_RUN);
        fetching_input_o = (state_q != c_RUN);
    end

    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_sequential_divider.sv
`default_nettype none
// ============================================================================
// tb_sequential_divider: directed checks of the restoring divider
// Revision: 1.0
// ============================================================================
module tb_sequential_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] dividend;
    logic [4:0] divisor;
    logic       start;
    logic [9:0] quotient;
    logic [4:0] remainder;
    logic       is_result, fetching, busy, dbz;

    int n_checks = 0;
    int n_fail   = 0;
    int cycles;
    logic ok;

    always #5 clk = ~clk;

    sequential_divider dut (
        .div_clk_i        (clk),
        .div_nreset_i     (rst_n),
        .dividend_i       (dividend),
        .divisor_i        (divisor),
        .start_i          (start),
        .quotient_o       (quotient),
        .remainder_o      (remainder),
        .is_result_o      (is_result),
        .fetching_input_o (fetching),
        .busy_o           (busy),
        .div_by_zero_o    (dbz)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [9:0] dd, input logic [4:0] dv);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Counts edges after the accepting edge until the result pulse is seen.
    task automatic wait_result(output int n);
        n = 0;
        while (!is_result && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic run_div(input string tag, input logic [9:0] dd, input logic [4:0] dv,
                           input logic [9:0] eq, input logic [4:0] er);
        int n;
        start_op(dd, dv);
        wait_result(n);
        chk({tag, "_latency"}, n, 10);
        chk({tag, "_quot"}, quotient, eq);
        chk({tag, "_rem"}, remainder, er);
        chk({tag, "_dbz"}, dbz, 0);
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        dividend = '0;
        divisor  = '0;
        start    = 1'b0;
        #12;
        chk("rst_quot", quotient, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_flags", {is_result, busy, fetching, dbz}, 4'b0010);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // 1000 / 7 with cycle-by-cycle flag checks
        start_op(10'h3E8, 5'd7);
        ok = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            if (!(busy && !is_result && !fetching)) ok = 1'b0;
            tick();
        end
        if (!(busy && !is_result)) ok = 1'b0;
        chk("d1000_busy_e0_e9", ok, 1);
        tick();
        chk("d1000_flags_e10", {is_result, busy, fetching}, 3'b101);
        chk("d1000_quot", quotient, 142);
        chk("d1000_rem", remainder, 6);
        chk("d1000_dbz", dbz, 0);
        tick();
        chk("d1000_pulse_end", is_result, 0);

        run_div("d961_31", 10'd961, 5'd31, 10'd31, 5'd0);
        run_div("d1023_1", 10'd1023, 5'd1, 10'd1023, 5'd0);
        run_div("d5_31", 10'd5, 5'd31, 10'd0, 5'd5);
        run_div("d0_9", 10'd0, 5'd9, 10'd0, 5'd0);

        // divide by zero, then a normal op clears the flag
        start_op(10'h155, 5'd0);
        wait_result(cycles);
        chk("dz_latency", cycles, 0);
        chk("dz_quot", quotient, 10'h3FF);
        chk("dz_rem", remainder, 0);
        chk("dz_flag", dbz, 1);
        tick();
        run_div("d20_3", 10'd20, 5'd3, 10'd6, 5'd2);

        // start/operands jitter during RUN is ignored; old result held
        start_op(10'h3E8, 5'd7);
        for (int i = 1; i <= 5; i++) begin
            start    = i[0];
            dividend = 10'(i * 37);
            divisor  = 5'(i);
            tick();
        end
        chk("jitter_hold_quot", quotient, 6);
        chk("jitter_hold_rem", remainder, 2);
        start = 1'b0;
        wait_result(cycles);
        chk("jitter_latency", cycles, 5);
        chk("jitter_quot", quotient, 142);
        chk("jitter_rem", remainder, 6);
        tick();

        // asynchronous reset mid-RUN
        start_op(10'h3E8, 5'd7);
        for (int i = 1; i <= 5; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_quot", quotient, 0);
        chk("arst_rem", remainder, 0);
        chk("arst_flags", {is_result, busy, fetching, dbz}, 4'b0010);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (is_result) ok = 1'b0;
            tick();
        end
        chk("arst_no_pulse", ok, 1);
        run_div("d100_10", 10'd100, 5'd10, 10'd10, 5'd0);

        // back-to-back with start held high
        dividend = 10'h3E8;
        divisor  = 5'd7;
        start    = 1'b1;
        tick();
        wait_result(cycles);
        chk("b2b_first_latency", cycles, 10);
        chk("b2b_first_quot", quotient, 142);
        chk("b2b_first_rem", remainder, 6);
        dividend = 10'd961;
        divisor  = 5'd31;
        cycles   = 0;
        do begin
            tick();
            cycles++;
        end while (!is_result && cycles < 30);
        start = 1'b0;
        chk("b2b_spacing", cycles, 11);
        chk("b2b_second_quot", quotient, 31);
        chk("b2b_second_rem", remainder, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
